instr_fetch: RTL

//  Instruction fetch unit: the requesting end of the synchronous instruction ROM port.

---
 rtl/instr_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the synchronous ROM port, absorbs its 1-cycle
// read latency and hands words plus PC to decode over valid/ready.
// Ports:
//   clock, reset_n              clock / async active-low reset
//   rom_addr, rom_q             ROM address out, registered ROM data in
//   instr, instr_pc, instr_valid, instr_ready   decode handshake
//   redirect_valid, redirect_pc                 branch flush/refetch
//   halted                      HALT_WORD fetched, fetching stopped
module instr_fetch #(
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              infl_v_q, infl_v_d;
    logic [ADDR_W-1:0] infl_pc_q, infl_pc_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] skid_w_q, skid_w_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic              out_v_q, out_v_d;
    logic [DATA_W-1:0] out_w_q, out_w_d;
    logic [ADDR_W-1:0] out_pc_q, out_pc_d;

    logic              out_free;
    logic              load_v;
    logic [DATA_W-1:0] load_w;
    logic [ADDR_W-1:0] load_pc;
    logic              resp_to_skid;
    logic              halt_hit;
    logic              issue;

    assign rom_addr    = fetch_pc_q;
    assign instr       = out_w_q;
    assign instr_pc    = out_pc_q;
    assign instr_valid = out_v_q;
    assign halted      = (state_q == ST_HALTED);

    always_comb begin
        out_free = !out_v_q || instr_ready;
        // Skid holds the older word, so it wins the output stage.
        load_v   = out_free && (skid_v_q || infl_v_q);
        load_w   = skid_v_q ? skid_w_q : rom_q;
        load_pc  = skid_v_q ? skid_pc_q : infl_pc_q;
        halt_hit = load_v && (load_w == HALT_WORD)
                   && (state_q == ST_RUN);

        // A response that cannot reach the output stage parks in skid.
        resp_to_skid = infl_v_q && (skid_v_q || !out_free);

        skid_v_d  = resp_to_skid || (skid_v_q && !out_free);
        skid_w_d  = resp_to_skid ? rom_q : skid_w_q;
        skid_pc_d = resp_to_skid ? infl_pc_q : skid_pc_q;

        // Issue only if the reply can be absorbed next cycle.
        issue = (state_q == ST_RUN) && !skid_v_d
                && !halt_hit && !redirect_valid;

        infl_v_d   = issue;
        infl_pc_d  = fetch_pc_q;
        fetch_pc_d = issue ? ADDR_W'(fetch_pc_q + 1'b1) : fetch_pc_q;

        out_v_d  = load_v || (out_v_q && !instr_ready);
        out_w_d  = load_v ? load_w : out_w_q;
        out_pc_d = load_v ? load_pc : out_pc_q;
        state_d  = state_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            infl_v_d   = 1'b0;
            skid_v_d   = 1'b0;
            out_v_d    = 1'b0;
            state_d    = ST_RUN;
        end else if (halt_hit) begin
            infl_v_d = 1'b0;
            skid_v_d = 1'b0;
            state_d  = ST_HALTED;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            fetch_pc_q <= RESET_PC;
            infl_v_q   <= 1'b0;
            infl_pc_q  <= '0;
            skid_v_q   <= 1'b0;
            skid_w_q   <= '0;
            skid_pc_q  <= '0;
            out_v_q    <= 1'b0;
            out_w_q    <= '0;
            out_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            infl_v_q   <= infl_v_d;
            infl_pc_q  <= infl_pc_d;
            skid_v_q   <= skid_v_d;
            skid_w_q   <= skid_w_d;
            skid_pc_q  <= skid_pc_d;
            out_v_q    <= out_v_d;
            out_w_q    <= out_w_d;
            out_pc_q   <= out_pc_d;
        end
    end

endmodule
